// File: rtl/mtimer_clint_if.sv
// Wishbone B4 classic register-port bundle. DAT_O is master write data and
// DAT_I is slave read data, both named from the master's side.
interface WB4 (input logic clk);
  logic [31:0] ADR;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        WE;
  logic        STB;
  logic        CYC;
  logic        ACK;

  modport slave  (input clk, ADR, DAT_O, WE, STB, CYC, output DAT_I, ACK);
  modport master (input clk, DAT_I, ACK, output ADR, DAT_O, WE, STB, CYC);
endinterface

// File: rtl/mtimer_clint.sv
// CLINT-style machine timer: prescaled 64-bit mtime, per-hart mtimecmp/timer_irq,
// optional per-hart msip/soft_irq (enabled by defining CLINT_MSIP_EN).
module clint_hart (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] mtime,
  input  logic [31:0] wdata,
  input  logic        cmp_wr_lo,
  input  logic        cmp_wr_hi,
  input  logic        msip_wr,
  output logic [63:0] cmp,
  output logic        msip,
  output logic        timer_irq
);
  logic [63:0] cmp_nxt;

  assign cmp_nxt = {cmp_wr_hi ? wdata : cmp[63:32], cmp_wr_lo ? wdata : cmp[31:0]};

  // Compare against the value being written so a raised compare drops the
  // interrupt in the very next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp       <= '1;
      timer_irq <= 1'b0;
    end else begin
      cmp       <= cmp_nxt;
      timer_irq <= (mtime >= cmp_nxt);
    end
  end

`ifdef CLINT_MSIP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       msip <= 1'b0;
    else if (msip_wr) msip <= wdata[0];
  end
`else
  logic unused_msip_wr;
  assign unused_msip_wr = msip_wr;
  assign msip = 1'b0;
`endif
endmodule

module mtimer_clint #(
  parameter int NUM_HARTS  = 1,
  parameter int PRESCALE_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  WB4.slave                    wb,
  output logic [NUM_HARTS-1:0] timer_irq,
  output logic [NUM_HARTS-1:0] soft_irq
);
  logic [15:0]                  adr;
  logic [31:0]                  wdata, rdata;
  logic                         access, ack, wr, rd;
  logic                         hit_ctrl, hit_shadow, hit_lo, hit_hi;
  logic [NUM_HARTS-1:0]         msip_sel, cmp_sel, msip;
  logic [NUM_HARTS-1:0][63:0]   cmp;
  logic [63:0]                  mtime;
  logic [31:0]                  shadow;
  logic                         en, tick;
  logic [PRESCALE_W-1:0]        div, cnt;
  logic                         unused_bits;

  assign unused_bits = ^{wb.clk, wb.ADR[31:16], wb.ADR[1:0]};

  assign adr    = wb.ADR[15:0];
  assign wdata  = wb.DAT_O;
  assign access = wb.STB & wb.CYC;
  assign wr     = ack & access & wb.WE;
  assign rd     = ack & access & ~wb.WE;

  assign hit_ctrl   = (adr[15:2] == 14'h2FFC);
  assign hit_shadow = (adr[15:2] == 14'h2FFD);
  assign hit_lo     = (adr[15:2] == 14'h2FFE);
  assign hit_hi     = (adr[15:2] == 14'h2FFF);

  // ACK toggles off between accesses, so a held STB gets one ACK per 2 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack <= 1'b0;
    else        ack <= access & ~ack;
  end
  assign wb.ACK = ack;

  assign tick = en && (cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en  <= 1'b1;
      div <= '0;
      cnt <= '0;
    end else if (wr && hit_ctrl) begin
      en  <= wdata[0];
      div <= wdata[PRESCALE_W+7:8];
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  // A bus write to either half beats a same-cycle tick; the other half holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 mtime <= '0;
    else if (wr && hit_lo)      mtime[31:0]  <= wdata;
    else if (wr && hit_hi)      mtime[63:32] <= wdata;
    else if (tick)              mtime <= mtime + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            shadow <= '0;
    else if (rd && hit_lo) shadow <= mtime[63:32];
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    assign msip_sel[h] = (adr[15:14] == 2'b00) && (adr[13:2] == 12'(h));
    assign cmp_sel[h]  = (adr[15:14] == 2'b01) && (adr[13:3] == 11'(h));

    clint_hart u_hart (
      .clk       (clk),
      .rst_n     (rst_n),
      .mtime     (mtime),
      .wdata     (wdata),
      .cmp_wr_lo (wr & cmp_sel[h] & ~adr[2]),
      .cmp_wr_hi (wr & cmp_sel[h] &  adr[2]),
      .msip_wr   (wr & msip_sel[h]),
      .cmp       (cmp[h]),
      .msip      (msip[h]),
      .timer_irq (timer_irq[h])
    );
  end

  assign soft_irq = msip;

  always_comb begin
    rdata = '0;
    if (hit_ctrl)   rdata = 32'({div, 7'b0, en});
    if (hit_shadow) rdata = shadow;
    if (hit_lo)     rdata = mtime[31:0];
    if (hit_hi)     rdata = mtime[63:32];
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (msip_sel[h]) rdata = {31'b0, msip[h]};
      if (cmp_sel[h])  rdata = adr[2] ? cmp[h][63:32] : cmp[h][31:0];
    end
  end

  assign wb.DAT_I = ack ? rdata : '0;
endmodule

// File: tb/tb_mtimer_clint.sv
// Directed bench for mtimer_clint with four harts; msip checks follow CLINT_MSIP_EN.
module tb_mtimer_clint;
  localparam int NH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NH-1:0] timer_irq, soft_irq;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  WB4 bus (.clk(clk));

  mtimer_clint #(.NUM_HARTS(NH), .PRESCALE_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (bus),
    .timer_irq (timer_irq),
    .soft_irq  (soft_irq)
  );

  // Starts at posedge+1, returns at posedge+1 just after the commit edge.
  task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                      output logic [31:0] rdat);
    logic got;
    got = 1'b0;
    bus.ADR = adr; bus.WE = we; bus.DAT_O = wd; bus.STB = 1'b1; bus.CYC = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      got = bus.ACK;
    end
    rdat = bus.DAT_I;
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("FAIL wb_ack adr=%h got=%b want=1", adr, got);
    end
    @(posedge clk); #1;
    bus.STB = 1'b0; bus.CYC = 1'b0; bus.WE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    xfer(adr, 1'b1, d, dummy);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    xfer(adr, 1'b0, 32'h0, d);
  endtask

  task automatic test_reset;
    logic [31:0] v;
    repeat (2) @(posedge clk); #1;
    total++;
    if ({bus.ACK, timer_irq, soft_irq} !== '0) begin
      bad++; $display("FAIL reset_outs got=%b want=0", {bus.ACK, timer_irq, soft_irq});
    end
    rst_n = 1'b1;
    rd(32'hBFF8, v); total++;
    if (v !== 32'd1) begin bad++; $display("FAIL reset_mtime0 got=%h want=1", v); end
    rd(32'hBFF8, v); total++;
    if (v !== 32'd3) begin bad++; $display("FAIL reset_mtime1 got=%h want=3", v); end
    rd(32'hBFF0, v); total++;
    if (v !== 32'h1) begin bad++; $display("FAIL reset_ctrl got=%h want=1", v); end
    rd(32'h4000, v); total++;
    if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_cmp_lo got=%h want=ffffffff", v); end
    rd(32'h4004, v); total++;
    if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_cmp_hi got=%h want=ffffffff", v); end
    rd(32'hBFF4, v); total++;
    if (v !== 32'h0) begin bad++; $display("FAIL reset_shadow got=%h want=0", v); end
  endtask

  task automatic test_ack_timing;
    bus.ADR = 32'hBFF0; bus.WE = 1'b0; bus.STB = 1'b1; bus.CYC = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.ACK !== ((i % 2) == 0)) begin
        bad++; $display("FAIL ack_pattern cyc=%0d got=%b want=%b", i, bus.ACK, (i % 2) == 0);
      end
    end
    bus.STB = 1'b0; bus.CYC = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_prescale;
    logic [31:0] r [5];
    logic [31:0] a, b, v;
    wr(32'hBFF0, 32'h0000_0301);
    for (int i = 0; i < 5; i++) rd(32'hBFF8, r[i]);
    total++;
    if (r[1] - r[0] !== 32'd0 || r[2] - r[0] !== 32'd1 || r[3] - r[0] !== 32'd1 ||
        r[4] - r[0] !== 32'd2) begin
      bad++; $display("FAIL div3_steps got=%h %h %h %h %h want=m,m,m+1,m+1,m+2",
                      r[0], r[1], r[2], r[3], r[4]);
    end
    rd(32'hBFF0, v); total++;
    if (v !== 32'h0000_0301) begin bad++; $display("FAIL ctrl_div3 got=%h want=00000301", v); end
    wr(32'hBFF0, 32'hFFFF_FFFE);
    rd(32'hBFF0, v); total++;
    if (v !== 32'h00FF_FF00) begin bad++; $display("FAIL ctrl_mask got=%h want=00ffff00", v); end
    rd(32'hBFF8, a);
    repeat (100) @(posedge clk);
    #1;
    rd(32'hBFF8, b); total++;
    if (b !== a) begin bad++; $display("FAIL en0_freeze got=%h want=%h", b, a); end
  endtask

  task automatic test_mtime_rw;
    logic [31:0] v;
    wr(32'hBFF0, 32'h0);
    wr(32'hBFFC, 32'h0);
    wr(32'hBFF8, 32'hFFFF_FFFE);
    wr(32'hBFF0, 32'h1);
    rd(32'hBFF8, v); total++;
    if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL pre_wrap_lo got=%h want=ffffffff", v); end
    rd(32'hBFF4, v); total++;
    if (v !== 32'h0) begin bad++; $display("FAIL pre_wrap_shadow got=%h want=0", v); end
    rd(32'hBFF8, v); total++;
    if (v !== 32'h3) begin bad++; $display("FAIL post_wrap_lo got=%h want=3", v); end
    rd(32'hBFF4, v); total++;
    if (v !== 32'h1) begin bad++; $display("FAIL post_wrap_shadow got=%h want=1", v); end
    wr(32'hBFF8, 32'd100);
    rd(32'hBFF8, v); total++;
    if (v !== 32'd101) begin bad++; $display("FAIL write_wins got=%h want=65", v); end
    wr(32'hBFF0, 32'h0);
    wr(32'hBFFC, 32'hFFFF_FFFF);
    wr(32'hBFF8, 32'hFFFF_FFFF);
    wr(32'hBFF0, 32'h1);
    rd(32'hBFFC, v); total++;
    if (v !== 32'h0) begin bad++; $display("FAIL wrap64_hi got=%h want=0", v); end
    rd(32'hBFF8, v); total++;
    if (v !== 32'h2) begin bad++; $display("FAIL wrap64_lo got=%h want=2", v); end
  endtask

  task automatic test_timer;
    logic [31:0] v;
    wr(32'hBFF0, 32'h0);
    wr(32'hBFFC, 32'h0);
    wr(32'hBFF8, 32'd9);
    wr(32'h4004, 32'h0);
    wr(32'h4000, 32'd10);
    total++;
    if (timer_irq !== 4'b0000) begin bad++; $display("FAIL irq_below got=%b want=0000", timer_irq); end
    wr(32'hBFF8, 32'd10);
    total++;
    if (timer_irq[0] !== 1'b0) begin bad++; $display("FAIL irq_reg_delay got=%b want=0", timer_irq[0]); end
    @(posedge clk); #1;
    total++;
    if (timer_irq[0] !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b want=1", timer_irq[0]); end
    wr(32'h4014, 32'h0);
    wr(32'h4010, 32'd30);
    wr(32'h400C, 32'h0);
    wr(32'h4008, 32'd5);
    @(posedge clk); #1;
    total++;
    if (timer_irq !== 4'b0011) begin bad++; $display("FAIL irq_indep got=%b want=0011", timer_irq); end
    wr(32'h4004, 32'hFFFF_FFFF);
    total++;
    if (timer_irq !== 4'b0010) begin bad++; $display("FAIL irq_clear got=%b want=0010", timer_irq); end
    wr(32'h4020, 32'h0);
    rd(32'h4020, v); total++;
    if (v !== 32'h0) begin bad++; $display("FAIL hart_oob got=%h want=0", v); end
    rd(32'h4013, v); total++;
    if (v !== 32'd30) begin bad++; $display("FAIL cmp2_lo_adr10 got=%h want=1e", v); end
    rd(32'hBFE0, v); total++;
    if (v !== 32'h0) begin bad++; $display("FAIL unmapped got=%h want=0", v); end
  endtask

  task automatic test_msip;
    logic [31:0] v;
`ifdef CLINT_MSIP_EN
    wr(32'h0004, 32'hFFFF_FFFF);
    total++;
    if (soft_irq !== 4'b0010) begin bad++; $display("FAIL msip_set got=%b want=0010", soft_irq); end
    rd(32'h0004, v); total++;
    if (v !== 32'h1) begin bad++; $display("FAIL msip_read got=%h want=1", v); end
    wr(32'h0004, 32'h0);
    total++;
    if (soft_irq !== 4'b0000) begin bad++; $display("FAIL msip_clr got=%b want=0000", soft_irq); end
    wr(32'h0004, 32'h1);
`else
    wr(32'h0004, 32'h1);
    total++;
    if (soft_irq !== 4'b0000) begin bad++; $display("FAIL msip_off got=%b want=0000", soft_irq); end
    rd(32'h0004, v); total++;
    if (v !== 32'h0) begin bad++; $display("FAIL msip_off_read got=%h want=0", v); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    bus.ADR = 32'hBFF0; bus.WE = 1'b1; bus.DAT_O = 32'h0; bus.STB = 1'b1; bus.CYC = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({timer_irq, soft_irq} !== '0) begin
      bad++; $display("FAIL mid_rst_irqs got=%b want=0", {timer_irq, soft_irq});
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.ACK !== 1'b0) begin bad++; $display("FAIL mid_rst_ack got=%b want=0", bus.ACK); end
    bus.STB = 1'b0; bus.CYC = 1'b0; bus.WE = 1'b0;
    rst_n = 1'b1;
    rd(32'hBFF0, v); total++;
    if (v !== 32'h1) begin bad++; $display("FAIL mid_rst_ctrl got=%h want=1", v); end
    rd(32'h4000, v); total++;
    if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mid_rst_cmp got=%h want=ffffffff", v); end
    rd(32'h0004, v); total++;
    if (v !== 32'h0) begin bad++; $display("FAIL mid_rst_msip got=%h want=0", v); end
  endtask

  initial begin
    bus.ADR = '0; bus.DAT_O = '0; bus.WE = 1'b0; bus.STB = 1'b0; bus.CYC = 1'b0;
    test_reset;
    test_ack_timing;
    test_prescale;
    test_mtime_rw;
    test_timer;
    test_msip;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mtimer_clint.md
MTIMER_CLINT -- requirements
Module: mtimer_clint

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 1, number of hart timer/software-interrupt channels (legal 1..8).
REQ-002 SHALL have parameter PRESCALE_W, default 16, width of the tick prescaler divisor.
REQ-003 SHALL have port clk  input  1  single clock; same net as wb.clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wb  WB4.slave  -  Wishbone B4 register port: ADR, DAT_O (write data), DAT_I (read data), WE, STB, CYC, ACK.
REQ-006 SHALL have port timer_irq  output  NUM_HARTS  per-hart machine timer interrupt level.
REQ-007 SHALL have port soft_irq  output  NUM_HARTS  per-hart machine software interrupt level.

Function
REQ-008 SHALL decode wb.ADR[15:0]: 0x0000+4h msip[h]; 0x4000+8h mtimecmp[h] low; 0x4004+8h mtimecmp[h] high; 0xBFF0 CTRL; 0xBFF4 mtime-high shadow; 0xBFF8 mtime low; 0xBFFC mtime high.
REQ-009 SHALL ignore ADR[1:0]; full 32-bit word accesses only; no byte lanes.
REQ-010 SHALL assert ACK exactly one cycle after the first cycle with STB&CYC high, for one cycle, once per access; back-to-back accesses take 2 cycles each.
REQ-011 SHALL drive DAT_I from registers during the ACK cycle; unmapped addresses and h>=NUM_HARTS read 0, ignore writes, still ACK.
REQ-012 SHALL commit writes in the ACK cycle only.
REQ-013 CTRL: bit0 EN (count enable), bits[PRESCALE_W+7:8] DIV; other bits read 0.
REQ-014 Prescaler counter SHALL count 0..DIV while EN=1 and emit one tick on reaching DIV, then wrap to 0; DIV=0 ticks every cycle.
REQ-015 mtime SHALL increment by 1 on each tick, 64-bit, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-016 EN=0 SHALL freeze mtime and prescaler counter; writing CTRL SHALL clear the prescaler counter.
REQ-017 Write to mtime low/high SHALL replace only that half; on same-cycle tick the write wins and the other half is not incremented.
REQ-018 Reading mtime low SHALL capture mtime[63:32] into the shadow register in the same cycle; shadow reads return it (tear-free 64-bit read).
REQ-019 timer_irq[h] SHALL be registered: 1 the cycle after mtime >= mtimecmp[h] (unsigned 64-bit), 0 the cycle after it is not.
REQ-020 Writing mtimecmp[h] beyond mtime SHALL clear timer_irq[h] on the following cycle.
REQ-021 msip[h] bit0 SHALL be read/write, other bits read 0; soft_irq[h] = msip[h] bit0 combinationally.

Reset
REQ-022 rst_n low SHALL immediately force: mtime=0, shadow=0, prescaler=0, every mtimecmp=all ones, msip=0, CTRL EN=1 DIV=0, ACK=0, timer_irq=0, soft_irq=0.
REQ-023 Reset mid-access SHALL abort it with no ACK and no write; the first post-reset access behaves per REQ-010.

Configuration
REQ-024 Macro CLINT_MSIP_EN defined: msip registers and soft_irq behave per REQ-021.
REQ-025 CLINT_MSIP_EN undefined: no msip storage; 0x0000 range reads 0, writes ignored but ACKed; soft_irq tied 0.

Verification
REQ-026 Reset, DIV=0: mtimecmp[0]=10 -> mtime reads 0,1,2..; timer_irq[0] rises the cycle after mtime=10.
REQ-027 CTRL DIV=3 -> mtime increments once per 4 cycles; CTRL EN=0 -> mtime constant across 100 cycles.
REQ-028 mtime high=0, low=0xFFFF_FFFE; read low after wrap -> shadow returns 1 while low returns 0..small, never torn.
REQ-029 timer_irq[0] high, write mtimecmp[0] high=0xFFFF_FFFF -> timer_irq[0] low next cycle; NUM_HARTS=4 channels independent.
REQ-030 CLINT_MSIP_EN on: write 1 to 0x0004 -> soft_irq=0b0010; off: read 0x0004 -> 0, soft_irq=0.
REQ-031 rst_n pulsed low during STB&CYC -> no ACK, registers at reset values, mtimecmp reads 0xFFFF_FFFF.
